// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// per-cycle control bundle driven to pc_reg, if_id and id_ex.
package pipe_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned FCNT_W = 3;

  typedef enum logic [1:0] {
    PC_IDLE   = 2'd0,
    PC_JFLUSH = 2'd1,
    PC_MCWAIT = 2'd2
  } pc_state_e;

  typedef struct packed {
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              hold_pc;
    logic              hold_if_id;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              mc_err;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module pipe_ctrl_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump flush, multi-cycle-op stall with timeout,
// load-use bubble. Perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned JUMP_FLUSH_CYC = 1,
  parameter int unsigned MC_TIMEOUT     = 64
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W          = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              mc_start_i,
  input  logic              mc_done_i,
  input  logic              load_use_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              mc_err_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  localparam int unsigned TCNT_W = $clog2(MC_TIMEOUT);

  pc_state_e         state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  ctrl_t             ctrl;

  // State and sequencing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PC_IDLE;
      fcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // Next state and zero-latency control outputs; everything forced low in reset
  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    fcnt_nxt  = fcnt;
    tcnt_nxt  = tcnt;
    if (!rst) begin
      case (state)
        PC_IDLE: begin
          if (jump_en_i) begin
            ctrl.jump_en     = 1'b1;
            ctrl.jump_addr   = jump_addr_i;
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            if (JUMP_FLUSH_CYC > 1) begin
              state_nxt = PC_JFLUSH;
              fcnt_nxt  = FCNT_W'(JUMP_FLUSH_CYC - 1);
            end
          end else if (mc_start_i) begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_if_id  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            state_nxt        = PC_MCWAIT;
            tcnt_nxt         = '0;
          end else if (load_use_i) begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_if_id  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
          end
        end
        PC_JFLUSH: begin
          ctrl.flush_if_id = 1'b1;
          ctrl.flush_id_ex = 1'b1;
          fcnt_nxt         = fcnt - FCNT_W'(1);
          if (fcnt <= FCNT_W'(1)) begin
            state_nxt = PC_IDLE;
          end
        end
        PC_MCWAIT: begin
          // done wins over a coincident timeout
          if (mc_done_i) begin
            state_nxt = PC_IDLE;
          end else if (tcnt == TCNT_W'(MC_TIMEOUT - 1)) begin
            ctrl.mc_err = 1'b1;
            state_nxt   = PC_IDLE;
          end else begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_if_id  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            tcnt_nxt         = tcnt + TCNT_W'(1);
          end
        end
        default: state_nxt = PC_IDLE;
      endcase
    end
  end

  assign jump_en_o     = ctrl.jump_en;
  assign jump_addr_o   = ctrl.jump_addr;
  assign hold_pc_o     = ctrl.hold_pc;
  assign hold_if_id_o  = ctrl.hold_if_id;
  assign flush_if_id_o = ctrl.flush_if_id;
  assign flush_id_ex_o = ctrl.flush_id_ex;
  assign mc_err_o      = ctrl.mc_err;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (ctrl.hold_pc),
    .cnt (stall_cnt_o)
  );

  pipe_ctrl_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (ctrl.flush_id_ex),
    .cnt (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int unsigned JFC = 2;
  localparam int unsigned MCT = 64;
  localparam int unsigned CW  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i, mc_start_i, mc_done_i, load_use_i;
  logic [31:0] jump_addr_i;
  logic        jump_en_o, hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, mc_err_o;
  logic [31:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(
    .JUMP_FLUSH_CYC (JFC),
    .MC_TIMEOUT     (MCT)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .CNT_W          (CW)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .mc_start_i    (mc_start_i),
    .mc_done_i     (mc_done_i),
    .load_use_i    (load_use_i),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o),
    .hold_pc_o     (hold_pc_o),
    .hold_if_id_o  (hold_if_id_o),
    .flush_if_id_o (flush_if_id_o),
    .flush_id_ex_o (flush_id_ex_o),
    .mc_err_o      (mc_err_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  typedef struct {
    bit          jump_en;
    bit [31:0]   jump_addr;
    bit          hold_pc;
    bit          hold_if_id;
    bit          flush_if_id;
    bit          flush_id_ex;
    bit          mc_err;
    longint      stall;
    longint      flush;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Behavioural model: remaining flush cycles, outstanding mc op and its age
  int     flush_left = 0;
  bit     mc_busy    = 1'b0;
  int     mc_age     = 0;
  longint m_stall    = 0;
  longint m_flush    = 0;
  longint cnt_max    = (longint'(1) << CW) - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit j, input logic [31:0] a,
                      input bit ms, input bit md, input bit lu);
    exp_t e;
    @(negedge clk);
    rst = r; jump_en_i = j; jump_addr_i = a;
    mc_start_i = ms; mc_done_i = md; load_use_i = lu;
    e = '{default: 0};
    e.stall = m_stall;
    e.flush = m_flush;
    if (r) begin
      flush_left = 0;
      mc_busy    = 1'b0;
    end else if (flush_left > 0) begin
      e.flush_if_id = 1'b1;
      e.flush_id_ex = 1'b1;
      flush_left--;
    end else if (mc_busy) begin
      if (md) begin
        mc_busy = 1'b0;
      end else if (mc_age == int'(MCT)) begin
        e.mc_err = 1'b1;
        mc_busy  = 1'b0;
      end else begin
        e.hold_pc = 1'b1; e.hold_if_id = 1'b1; e.flush_id_ex = 1'b1;
        mc_age++;
      end
    end else if (j) begin
      e.jump_en     = 1'b1;
      e.jump_addr   = a;
      e.flush_if_id = 1'b1;
      e.flush_id_ex = 1'b1;
      flush_left    = int'(JFC) - 1;
    end else if (ms) begin
      e.hold_pc = 1'b1; e.hold_if_id = 1'b1; e.flush_id_ex = 1'b1;
      mc_busy = 1'b1;
      mc_age  = 1;
    end else if (lu) begin
      e.hold_pc = 1'b1; e.hold_if_id = 1'b1; e.flush_id_ex = 1'b1;
    end
    if (r) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e.hold_pc && m_stall != cnt_max) m_stall++;
      if (e.flush_id_ex && m_flush != cnt_max) m_flush++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare mid-cycle
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("jump_en",     64'(jump_en_o),     64'(e.jump_en));
      check("jump_addr",   64'(jump_addr_o),   64'(e.jump_addr));
      check("hold_pc",     64'(hold_pc_o),     64'(e.hold_pc));
      check("hold_if_id",  64'(hold_if_id_o),  64'(e.hold_if_id));
      check("flush_if_id", 64'(flush_if_id_o), 64'(e.flush_if_id));
      check("flush_id_ex", 64'(flush_id_ex_o), 64'(e.flush_id_ex));
      check("mc_err",      64'(mc_err_o),      64'(e.mc_err));
      check("if_id_excl",  64'(hold_if_id_o & flush_if_id_o), 64'(0));
`ifdef PIPE_CTRL_PERF_EN
      check("stall_cnt",   64'(stall_cnt_o),   64'(e.stall));
      check("flush_cnt",   64'(flush_cnt_o),   64'(e.flush));
`endif
    end
  end

  initial begin
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0;
    mc_start_i = 1'b0; mc_done_i = 1'b0; load_use_i = 1'b0;

    // Reset with noisy inputs
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    idle(2);

    // Taken jump
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Multi-cycle op completing 10 cycles after issue
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(9);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Multi-cycle op that never completes
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(70);

    // All requests at once, then the jump-flush window with noise
    step(1'b0, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Single load-use bubble, then a persisting one
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Reset in the middle of a multi-cycle wait; the late done is stale
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 5) == 0,
           $urandom,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0);
    end
    idle(2);

    @(negedge clk);
    #4;
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
